// File: rtl/axil_ram_pkg.sv
// Shared AXI-lite definitions for the axil_ram slave: response codes and
// the word-index width helper used to size the memory array.
package axil_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of address bits left once the byte-within-word bits are dropped.
  function automatic int word_idx_width(input int addr_width, input int strb_width);
    return addr_width - $clog2(strb_width);
  endfunction

endpackage

// File: rtl/axil_ram_if.sv
// AXI4-Lite bus bundle between a master (or crossbar) and the axil_ram slave.
interface axil_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_ram_rd_pipe.sv
// Read-response path of axil_ram: R register with valid/ready hold, plus an
// optional RAM output stage when AXIL_RAM_PIPELINE_EN is defined.
module axil_ram_rd_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  rready,
  output logic                  can_accept,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

`ifdef AXIL_RAM_PIPELINE_EN
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_adv;

  // Stage 1 moves into R whenever R is empty or being drained this cycle.
  assign s1_adv     = s1_valid && (!rvalid || rready);
  assign can_accept = !s1_valid || s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      if (load) begin
        s1_valid <= 1'b1;
        s1_data  <= word;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        rvalid <= 1'b1;
        rdata  <= s1_data;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end
`else
  assign can_accept = !rvalid || rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (load) begin
      rvalid <= 1'b1;
      rdata  <= word;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/axil_ram.sv
// AXI4-Lite slave RAM with byte strobes, one write and one read in flight.
// Define AXIL_RAM_PIPELINE_EN for a two-stage read path (two reads in flight).
module axil_ram
  import axil_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  axil_ram_if.slave s_axil
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = word_idx_width(ADDR_WIDTH, STRB_WIDTH);
  localparam int DEPTH      = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  bvalid;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_can_accept;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_bits;

  // AW and W are only ever taken together, and only once B has room.
  assign wr_fire = !rst && s_axil.awvalid && s_axil.wvalid && (!bvalid || s_axil.bready);
  assign rd_fire = !rst && s_axil.arvalid && rd_can_accept;

  assign s_axil.awready = wr_fire;
  assign s_axil.wready  = wr_fire;
  assign s_axil.arready = rd_fire;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.bresp   = RESP_OKAY;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rdata   = rdata;
  assign s_axil.rresp   = RESP_OKAY;

  assign wr_idx = s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];

  assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

  // Memory is deliberately left out of reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axil.wstrb[i]) begin
          mem[wr_idx][i*8 +: 8] <= s_axil.wdata[i*8 +: 8];
        end
      end
    end
  end

  // Combinational read sees pre-write contents when addresses collide.
  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0;
    end else if (wr_fire) begin
      bvalid <= 1'b1;
    end else if (s_axil.bready) begin
      bvalid <= 1'b0;
    end
  end

  axil_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .load       (rd_fire),
    .word       (rd_word),
    .rready     (s_axil.rready),
    .can_accept (rd_can_accept),
    .rvalid     (rvalid),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_axil_ram.sv
// Directed bench for axil_ram: expected B/R responses are queued at issue
// time and checked by an independent monitor when the DUT presents them.
module tb_axil_ram;
  import axil_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axil_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (bus.slave)
  );

`ifdef AXIL_RAM_PIPELINE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got bvalid=1 expected no response");
        end else begin
          chk("bresp", {30'd0, bus.bresp}, {30'd0, bq.pop_front()});
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got rvalid=1 expected no response");
        end else begin
          chk("rdata", bus.rdata, rq.pop_front());
          chk("rresp", {30'd0, bus.rresp}, {30'd0, RESP_OKAY});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok;
    bq.push_back(RESP_OKAY);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.awready && bus.wready) begin ok = 1; break; end
    end
    if (!ok) chk("wr_accept_timeout", 32'd0, 32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (bus.bready) begin
      @(negedge clk);
      chk("bvalid_latency", {31'd0, bus.bvalid}, 32'd1);
      tick();
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [31:0] exp);
    bit ok;
    int lat;
    rq.push_back(exp);
    bus.araddr = addr; bus.arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1; break; end
    end
    if (!ok) chk("rd_accept_timeout", 32'd0, 32'd1);
    tick();
    bus.arvalid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rvalid) break;
      @(posedge clk);
      lat++;
    end
    chk("rd_latency", lat, RD_LAT);
    tick();
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset: valids asserted must not be accepted
    repeat (3) tick();
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", {31'd0, bus.awready}, 32'd0);
    chk("rst_wready",  {31'd0, bus.wready},  32'd0);
    chk("rst_arready", {31'd0, bus.arready}, 32'd0);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", {31'd0, bus.awready}, 32'd0);
    chk("idle_wready",  {31'd0, bus.wready},  32'd0);
    chk("idle_arready", {31'd0, bus.arready}, 32'd0);
    chk("idle_bvalid",  {31'd0, bus.bvalid},  32'd0);
    chk("idle_rvalid",  {31'd0, bus.rvalid},  32'd0);
    chk("idle_rdata",   bus.rdata, 32'h0);
    tick();

    // Full word and partial strobe
    do_write(16'h0010, 32'hDEADBEEF, 4'hF);
    do_read(16'h0010, 32'hDEADBEEF);
    do_write(16'h0010, 32'h11223344, 4'b0101);
    do_read(16'h0010, 32'hDE22BE44);
    do_read(16'h0013, 32'hDE22BE44);

    // B stall: second write must wait, memory must not change
    bus.bready = 1'b0;
    do_write(16'h0030, 32'h12345678, 4'hF);
    bus.awaddr = 16'h0030; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    do_read(16'h0030, 32'h12345678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_bvalid",  {31'd0, bus.bvalid},  32'd1);
      chk("stall_bresp",   {30'd0, bus.bresp},   32'd0);
      chk("stall_awready", {31'd0, bus.awready}, 32'd0);
      chk("stall_wready",  {31'd0, bus.wready},  32'd0);
      tick();
    end
    bus.bready = 1'b1;
    bq.push_back(RESP_OKAY);
    @(negedge clk);
    chk("resume_awready", {31'd0, bus.awready}, 32'd1);
    chk("resume_wready",  {31'd0, bus.wready},  32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("resume_bvalid", {31'd0, bus.bvalid}, 32'd1);
    tick();
    do_read(16'h0030, 32'hCAFEF00D);

    // AW without W
    bq.push_back(RESP_OKAY);
    bus.awaddr = 16'h0040; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("aw_only_awready", {31'd0, bus.awready}, 32'd0);
      chk("aw_only_wready",  {31'd0, bus.wready},  32'd0);
      tick();
    end
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_awready", {31'd0, bus.awready}, 32'd1);
    chk("aw_w_wready",  {31'd0, bus.wready},  32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("aw_w_bvalid", {31'd0, bus.bvalid}, 32'd1);
    tick();
    do_read(16'h0040, 32'h0BADF00D);

    // Same-cycle read and write to one address
    do_write(16'h0020, 32'h00000000, 4'hF);
    bq.push_back(RESP_OKAY);
    rq.push_back(32'h00000000);
    bus.awaddr = 16'h0020; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
    bus.araddr = 16'h0020;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("same_awready", {31'd0, bus.awready}, 32'd1);
    chk("same_arready", {31'd0, bus.arready}, 32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    repeat (3) tick();
    do_read(16'h0020, 32'h5A5A5A5A);

    // R stall holds data
    bus.rready = 1'b0;
    do_read(16'h0040, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstall_rvalid", {31'd0, bus.rvalid}, 32'd1);
      chk("rstall_rdata",  bus.rdata, 32'h0BADF00D);
      tick();
    end
    bus.rready = 1'b1;
    tick();

    // Back-to-back reads
    rq.push_back(32'h5A5A5A5A);
    rq.push_back(32'hDE22BE44);
    bus.araddr = 16'h0020; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("b2b_arready1", {31'd0, bus.arready}, 32'd1);
    tick();
    bus.araddr = 16'h0010;
    @(negedge clk);
    chk("b2b_arready2", {31'd0, bus.arready}, 32'd1);
    tick();
    bus.arvalid = 1'b0;
    repeat (4) tick();

    // Reset mid-transaction drops the pending B, keeps memory
    bus.bready = 1'b0;
    do_write(16'h0050, 32'h77777777, 4'hF);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_drop_bvalid", {31'd0, bus.bvalid}, 32'd0);
    bq.delete();
    tick();
    rst = 1'b0;
    bus.bready = 1'b1;
    tick();
    do_read(16'h0010, 32'hDE22BE44);
    do_read(16'h0050, 32'h77777777);

    repeat (3) tick();
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_ram.md
# axil_ram

AXI4-Lite slave RAM: a byte-addressable, byte-strobed memory target that terminates the AXI-lite slave port and serves as the design-under-test for the AXI-lite slave property checker. It holds one write and one read transaction in flight, returns OKAY on every access, and guarantees the reset, stall and outstanding-count rules of the AXI-lite slave contract. It sits at the leaf of an AXI-lite interconnect, downstream of the master or crossbar.

## Interface
- DATA_WIDTH, 32, data bus width in bits; multiple of 8
- ADDR_WIDTH, 16, byte address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous to clk, active-high
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  byte enables
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake
- s_axil_bresp  out  2  always 2'b00
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  always 2'b00
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake

## Operation
- Depth: 2^(ADDR_WIDTH - log2(STRB_WIDTH)) words. Word index = addr >> log2(STRB_WIDTH); low address bits ignored (unaligned accesses are word-aligned).
- Write: awready = wready = !rst && awvalid && wvalid && (!bvalid || bready). AW and W are always accepted in the same cycle, never one alone. On acceptance, each byte i with wstrb[i]=1 is written; other bytes are unchanged. bvalid rises the next cycle and holds, with bresp stable, until bready.
- Read: arready = !rst && arvalid && read path can accept (below). On acceptance, the word is read into the R path; rvalid holds with rdata/rresp stable until rready.
- Same-address read and write accepted in the same cycle: the read returns the pre-write data.
- Outstanding: at most 1 write; at most 1 read (2 with pipeline).
- Reset: bvalid, rvalid, and all readies are 0; rdata is 0; memory contents are not cleared. Reset asserted mid-transaction drops pending responses without completing them.

## Timing
- Write: handshake in cycle N → bvalid in N+1. Back-to-back writes are possible if bready is held high: 1 write per cycle.
- Read (no pipeline): handshake in N → rvalid in N+1. Accept condition: !rvalid || rready. Throughput is 1 per cycle.
- Readies are combinational from valids and response state. Valids and data are registered.
- First cycle after rst deasserts: no ready and no response valid.

## Configuration
- AXIL_RAM_PIPELINE_EN defined: the read path gains a second register stage (RAM output register, then R register). Read latency becomes handshake N → rvalid N+2. The stage-1 word advances when the R register is empty or rready=1. arready requires stage 1 to be empty or advancing. Up to 2 reads are outstanding, and sustained throughput stays at 1 per cycle.
- Undefined: single-stage read as above.

## Structure
- The shared AXI package holds the response codes (OKAY=2'b00, SLVERR=2'b10) and a localparam helper for the word-index width.
- One natural sub-module, axil_ram_rd_pipe: the read-response register and the optional pipeline stage with valid/ready hold logic.

## Test plan
- Reset then idle: the cycle after rst falls, awready/wready/arready/bvalid/rvalid = 0.
- Write 0xDEADBEEF to 0x0010 with wstrb=4'hF, bready=1 → bvalid the next cycle, bresp=0. Read 0x0010 → rdata=0xDEADBEEF, rvalid at N+1 (N+2 with AXIL_RAM_PIPELINE_EN).
- Partial strobe: write 0x11223344 with wstrb=4'b0101 over 0xDEADBEEF → read returns 0xDE22BE44.
- Response stall: bready=0 for 10 cycles → bvalid and bresp held, awready=wready=0, no memory write. Then bready=1 → completes, next write accepted.
- awvalid without wvalid for 5 cycles → awready stays 0. Then wvalid rises → both readies high in the same cycle.
- Same-cycle read and write to 0x0020 (old 0x0, new 0x5A5A5A5A) → read returns 0x0. A subsequent read returns 0x5A5A5A5A.
